// File: rtl/counter_cmd_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : counter_cmd_seq_if
// Brief    : Command handshake and counter-drive bundle for counter_cmd_seq.
// Revision : 1.0 - initial release
// ============================================================================
interface counter_cmd_seq_if #(
    parameter int WIDTH = 16
) ();
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] cmd_arg;
    logic             cnt_rco;
    logic             cnt_enable;
    logic [1:0]       cnt_mode;
    logic [WIDTH-1:0] cnt_D;
    logic             busy;
    logic             done;
    logic [7:0]       rco_tally;

    modport master (
        output cmd_valid, cmd_op, cmd_arg, cnt_rco,
        input  cmd_ready, cnt_enable, cnt_mode, cnt_D, busy, done, rco_tally
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_arg, cnt_rco,
        output cmd_ready, cnt_enable, cnt_mode, cnt_D, busy, done, rco_tally
    );
endinterface
`default_nettype wire

// File: rtl/counter_cmd_seq.sv
`default_nettype none
// ============================================================================
// Module   : counter_cmd_seq
// Brief    : FIFO-buffered command sequencer driving a 16-bit counter.
// Revision : 1.0 - initial release
// ============================================================================
module counter_cmd_seq #(
    parameter int WIDTH      = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  wire logic         clk,
    input  wire logic         reset,
    counter_cmd_seq_if.slave  bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [1:0] OP_LOAD = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    logic [1:0]       fifo_op_q  [FIFO_DEPTH];
    logic [WIDTH-1:0] fifo_arg_q [FIFO_DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;

    state_t           state_q;
    logic             en_q;
    logic [1:0]       mode_q;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] remaining_q;
    logic             done_q;
    logic [7:0]       tally_q;

    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic [1:0]       w_head_op;
    logic [WIDTH-1:0] w_head_arg;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign w_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign w_empty = (wr_ptr_q == rd_ptr_q);
    assign w_push  = bus.cmd_valid && !w_full;
    assign w_pop   = (state_q == S_IDLE) && !w_empty;

    assign w_head_op  = fifo_op_q[rd_ptr_q[AW-1:0]];
    assign w_head_arg = fifo_arg_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (w_push) begin
            fifo_op_q[wr_ptr_q[AW-1:0]]  <= bus.cmd_op;
            fifo_arg_q[wr_ptr_q[AW-1:0]] <= bus.cmd_arg;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (w_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (w_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            en_q        <= 1'b0;
            mode_q      <= 2'b00;
            data_q      <= '0;
            remaining_q <= '0;
            done_q      <= 1'b0;
            tally_q     <= 8'd0;
        end else begin
            if (en_q && bus.cnt_rco && (tally_q != 8'hFF)) begin
                tally_q <= tally_q + 8'd1;
            end

            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    en_q   <= 1'b0;
                    if (w_pop) begin
                        if (w_head_op == OP_LOAD) begin
                            state_q <= S_LOAD;
                            en_q    <= 1'b1;
                            mode_q  <= OP_LOAD;
                            data_q  <= w_head_arg;
                        end else if (w_head_arg != '0) begin
                            state_q     <= S_RUN;
                            en_q        <= 1'b1;
                            mode_q      <= w_head_op;
                            remaining_q <= w_head_arg - 1'b1;
                            tally_q     <= 8'd0;
                        end else begin
                            // Zero-length count: completes without enabling.
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                            tally_q <= 8'd0;
                        end
                    end
                end
                S_RUN: begin
                    if (remaining_q == '0) begin
                        state_q <= S_DONE;
                        en_q    <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        remaining_q <= remaining_q - 1'b1;
                    end
                end
                S_LOAD: begin
                    state_q <= S_DONE;
                    en_q    <= 1'b0;
                    done_q  <= 1'b1;
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    en_q    <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cmd_ready  = !w_full;
    assign bus.cnt_enable = en_q;
    assign bus.cnt_mode   = mode_q;
    assign bus.cnt_D      = data_q;
    assign bus.busy       = (state_q != S_IDLE) || !w_empty;
    assign bus.done       = done_q;
    assign bus.rco_tally  = tally_q;
endmodule
`default_nettype wire

// File: tb/tb_counter_cmd_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_counter_cmd_seq
// Brief    : Directed self-checking bench for counter_cmd_seq.
// Revision : 1.0 - initial release
// ============================================================================
module tb_counter_cmd_seq;
    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    counter_cmd_seq_if #(.WIDTH(16)) bus ();

    counter_cmd_seq #(.WIDTH(16), .FIFO_DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Enable-run logger: start modes, run lengths, low gaps, done pulses.
    int         mon_starts = 0;
    int         mon_dones  = 0;
    int         cur_len    = 0;
    int         cur_gap    = 1000;
    logic       prev_en    = 1'b0;
    logic [1:0] mode_log [$];
    int         len_log  [$];
    int         gap_log  [$];

    always @(negedge clk) begin
        if (bus.done === 1'b1) mon_dones++;
        if (bus.cnt_enable === 1'b1) begin
            if (!prev_en) begin
                mon_starts++;
                mode_log.push_back(bus.cnt_mode);
                gap_log.push_back(cur_gap);
                cur_len = 0;
            end
            cur_len++;
        end else begin
            if (prev_en) len_log.push_back(cur_len);
            cur_gap = prev_en ? 1 : cur_gap + 1;
        end
        prev_en = (bus.cnt_enable === 1'b1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_cmd(input logic [1:0] op, input logic [15:0] arg, input int maxc,
                           output int en_cyc, output logic ok);
        bus.cmd_op    = op;
        bus.cmd_arg   = arg;
        bus.cmd_valid = 1'b1;
        tick();
        bus.cmd_valid = 1'b0;
        en_cyc = 0;
        ok     = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            tick();
            if (bus.cnt_enable === 1'b1) en_cyc++;
            if (bus.done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        tick();
    endtask

    initial begin
        int         en_cyc;
        logic       ok;
        int         s0, l0, g0, d0, st0, pushes, queued, n;
        logic       saw_full;
        logic [1:0] ops [6];

        reset         = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'b00;
        bus.cmd_arg   = 16'h0;
        bus.cnt_rco   = 1'b0;

        // Reset state
        tick(); tick();
        chk("rst_enable", bus.cnt_enable, 0);
        chk("rst_mode",   bus.cnt_mode, 0);
        chk("rst_D",      bus.cnt_D, 0);
        chk("rst_done",   bus.done, 0);
        chk("rst_tally",  bus.rco_tally, 0);
        chk("rst_ready",  bus.cmd_ready, 1);
        chk("rst_busy",   bus.busy, 0);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_enable", bus.cnt_enable, 0);
        end

        // Count up, 5 cycles
        run_cmd(2'b00, 16'd5, 50, en_cyc, ok);
        chk("run5_done_seen", ok, 1);
        chk("run5_en_cycles", en_cyc, 5);
        chk("run5_len",       len_log[len_log.size()-1], 5);
        chk("run5_mode",      mode_log[mode_log.size()-1], 0);
        chk("run5_busy_after", bus.busy, 0);
        chk("run5_done_after", bus.done, 0);

        // Load 0xBEEF
        bus.cmd_op = 2'b11; bus.cmd_arg = 16'hBEEF; bus.cmd_valid = 1'b1;
        tick();
        bus.cmd_valid = 1'b0;
        chk("load_pre_en", bus.cnt_enable, 0);
        tick();
        chk("load_en",   bus.cnt_enable, 1);
        chk("load_mode", bus.cnt_mode, 3);
        chk("load_D",    bus.cnt_D, 16'hBEEF);
        chk("load_done_early", bus.done, 0);
        tick();
        chk("load_en_off", bus.cnt_enable, 0);
        chk("load_done",   bus.done, 1);
        tick();
        chk("load_done_clr", bus.done, 0);
        chk("load_busy",     bus.busy, 0);
        chk("load_D_hold",   bus.cnt_D, 16'hBEEF);

        // FIFO fill with backpressure: six commands held on cmd_valid
        ops[0] = 2'b00; ops[1] = 2'b01; ops[2] = 2'b10;
        ops[3] = 2'b00; ops[4] = 2'b01; ops[5] = 2'b10;
        s0 = mode_log.size(); l0 = len_log.size(); g0 = gap_log.size();
        d0 = mon_dones; st0 = mon_starts;
        pushes = 0; queued = -1; saw_full = 1'b0;
        for (int k = 0; k < 6; k++) begin
            bus.cmd_op = ops[k]; bus.cmd_arg = 16'd3; bus.cmd_valid = 1'b1;
            n = 0;
            while (bus.cmd_ready !== 1'b1 && n < 200) begin
                if (!saw_full) begin
                    saw_full = 1'b1;
                    queued   = pushes - (mon_starts - st0);
                end
                tick();
                n++;
            end
            chk("fifo_ready_timeout", (n < 200), 1);
            tick();
            pushes++;
        end
        bus.cmd_valid = 1'b0;
        n = 0;
        while (((mon_dones - d0) < 6 || bus.busy !== 1'b0) && n < 500) begin
            tick();
            n++;
        end
        chk("fifo_drain_timeout", (n < 500), 1);
        chk("fifo_saw_full", saw_full, 1);
        chk("fifo_queued_at_full", queued, 4);
        chk("fifo_starts", mon_starts - st0, 6);
        chk("fifo_dones",  mon_dones - d0, 6);
        for (int k = 0; k < 6; k++) begin
            chk("fifo_order_mode", mode_log[s0+k], ops[k]);
            chk("fifo_len",        len_log[l0+k], 3);
            if (k > 0) chk("fifo_gap", gap_log[g0+k], 2);
        end

        // rco tally: 3 pulses within a 40-cycle count-by-3 run
        bus.cmd_op = 2'b10; bus.cmd_arg = 16'd40; bus.cmd_valid = 1'b1;
        tick();
        bus.cmd_valid = 1'b0;
        tick();
        chk("rco_en_start", bus.cnt_enable, 1);
        for (int i = 0; i < 40; i++) begin
            bus.cnt_rco = (i == 0 || i == 10 || i == 39);
            tick();
        end
        chk("rco_done",    bus.done, 1);
        chk("rco_en_off",  bus.cnt_enable, 0);
        chk("rco_tally3",  bus.rco_tally, 3);
        bus.cnt_rco = 1'b1;
        tick();
        chk("rco_tally_hold", bus.rco_tally, 3);
        bus.cnt_rco = 1'b0;

        // Saturation: rco stuck high for 300 enabled cycles
        bus.cnt_rco = 1'b1;
        run_cmd(2'b00, 16'd300, 400, en_cyc, ok);
        bus.cnt_rco = 1'b0;
        chk("sat_done_seen", ok, 1);
        chk("sat_en_cycles", en_cyc, 300);
        chk("sat_tally",     bus.rco_tally, 255);

        // A load does not clear the tally
        run_cmd(2'b11, 16'h1234, 20, en_cyc, ok);
        chk("load2_en_cycles", en_cyc, 1);
        chk("load2_tally",     bus.rco_tally, 255);

        // Zero-length count
        bus.cmd_op = 2'b01; bus.cmd_arg = 16'd0; bus.cmd_valid = 1'b1;
        tick();
        bus.cmd_valid = 1'b0;
        tick();
        chk("zero_done",  bus.done, 1);
        chk("zero_en",    bus.cnt_enable, 0);
        chk("zero_tally", bus.rco_tally, 0);
        tick();
        chk("zero_done_clr", bus.done, 0);
        chk("zero_busy",     bus.busy, 0);

        // Reset on the 3rd enabled cycle of a 10-cycle run, one command queued
        bus.cmd_op = 2'b00; bus.cmd_arg = 16'd10; bus.cmd_valid = 1'b1;
        tick();
        bus.cmd_op = 2'b01; bus.cmd_arg = 16'd7;
        tick();
        bus.cmd_valid = 1'b0;
        chk("mid_en1", bus.cnt_enable, 1);
        tick();
        tick();
        chk("mid_en3", bus.cnt_enable, 1);
        reset = 1'b1;
        tick();
        chk("mid_en_off",  bus.cnt_enable, 0);
        chk("mid_done",    bus.done, 0);
        chk("mid_busy",    bus.busy, 0);
        chk("mid_ready",   bus.cmd_ready, 1);
        reset = 1'b0;
        d0 = mon_dones; st0 = mon_starts;
        for (int i = 0; i < 5; i++) tick();
        chk("mid_no_done",  mon_dones - d0, 0);
        chk("mid_no_start", mon_starts - st0, 0);

        // Maximum run length: no wrap of the remaining counter
        run_cmd(2'b00, 16'hFFFF, 70000, en_cyc, ok);
        chk("max_done_seen", ok, 1);
        chk("max_en_cycles", en_cyc, 65535);
        chk("max_busy",      bus.busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/counter_cmd_seq.md
Name: counter_cmd_seq

Overview:
Command sequencer placed directly upstream of the 16-bit counter. It accepts counting commands over a valid/ready handshake, buffers them in a small FIFO and drives the counter's enable/mode/load-data inputs for an exact number of cycles. It also tallies the counter's ripple-carry-out (rco) pulses per command and flags completion.

Parameters:
WIDTH, 16, counter data width; also the width of the command argument.
FIFO_DEPTH, 4, command FIFO entries (power of 2, >= 2).

Ports:
clk  input  1  rising-edge clock for all state.
reset  input  1  synchronous, active-high reset.
cmd_valid  input  1  command offered.
cmd_ready  output  1  FIFO can accept a command (combinational, = !full).
cmd_op  input  2  00 count up, 01 count down, 10 count up by 3, 11 load.
cmd_arg  input  WIDTH  run length in cycles (ops 00/01/10) or load value (op 11).
cnt_rco  input  1  counter rco, sampled every cycle.
cnt_enable  output  1  counter enable, registered.
cnt_mode  output  2  counter mode, registered; equals the active cmd_op.
cnt_D  output  WIDTH  counter load data, registered.
busy  output  1  FSM not in IDLE, or FIFO not empty.
done  output  1  one-cycle pulse at command completion.
rco_tally  output  8  rco-high cycles seen during the last command; saturates at 255.

Behaviour:
- Reset (synchronous, clk edge with reset=1): FIFO emptied, FSM=IDLE, cnt_enable=0, cnt_mode=00, cnt_D=0, done=0, rco_tally=0, remaining=0. Takes priority over every other event. Reset mid-RUN: cnt_enable is 0 from the next edge; no done pulse is produced.
- Push: a command is written when cmd_valid && cmd_ready on a clk edge. When full, cmd_ready=0 and the command is held off; nothing is dropped.
- Pop: happens only in IDLE with the FIFO non-empty. Push and pop on the same edge are both honoured; the count is unchanged.
- FSM states: IDLE, LOAD, RUN, DONE.
- IDLE, no entry: cnt_enable=0; stay.
- IDLE, pop op=11: next state LOAD with cnt_enable=1, cnt_mode=11, cnt_D=arg for exactly 1 cycle.
- IDLE, pop op in {00,01,10} with arg>0: next state RUN with cnt_enable=1, cnt_mode=op, remaining=arg-1. rco_tally is cleared.
- IDLE, pop count op with arg=0: go straight to DONE; cnt_enable stays 0; rco_tally=0.
- RUN: cnt_enable stays 1. If remaining=0, go to DONE; otherwise decrement remaining. Net result: exactly arg consecutive enable cycles.
- LOAD: always goes to DONE.
- DONE: done=1 for 1 cycle, cnt_enable=0, then IDLE. Consecutive commands are therefore separated by at least 2 cycles with cnt_enable=0 (DONE plus IDLE pop).
- rco_tally: increments on each cycle where cnt_rco=1 and the registered cnt_enable=1 (RUN or LOAD). It holds at 255 and holds its value after done until the next count command clears it. A load command does not clear it.
- cnt_D holds its last value outside LOAD. cnt_mode holds the last op outside RUN/LOAD.
- Pop-to-enable latency: 1 clk (the command is popped at edge t; cnt_enable=1 is visible after edge t).
- remaining is WIDTH bits; arg=2^WIDTH-1 must produce exactly that many enable cycles with no wrap.

Test Plan:
- Reset then idle: reset held 2 cycles -> all outputs 0, cmd_ready=1, busy=0. Then 10 idle cycles -> cnt_enable stays 0.
- Count run: push (op=00, arg=5) -> cnt_enable=1 for exactly 5 cycles with cnt_mode=00, then done pulses once, then busy=0.
- Load: push (op=11, arg=0xBEEF) -> one cycle with cnt_enable=1, cnt_mode=11, cnt_D=0xBEEF, followed by done on the next cycle.
- FIFO full/backpressure: hold cmd_valid for 6 commands (arg=3 each) while the FSM is busy -> cmd_ready drops once 4 are queued. All 6 execute in order with the 2-cycle gap; none are lost or duplicated.
- rco tally: op=10, arg=40, bench drives cnt_rco high on 3 of the enabled cycles -> rco_tally=3 at done. A separate run with cnt_rco stuck high for 300 enabled cycles -> rco_tally=255.
- Corner cases:
  - arg=0 -> done pulse, no enable.
  - Reset asserted on the 3rd cycle of a 10-cycle run -> cnt_enable=0 next edge, no done, FIFO empty.
